ctl_round: RTL

- Game-flow controller for Duck Hunt; sits downstream of ctl_trigger (consumes hit/miss/shot_fired) and upstream of ctl_duck, ctl_ammo and draw_overlay.
- Sequences ducks within a round, counts hits per round, decides pass or fail, and drives the round number to the 7-seg mux.
- Issues duck-release and ammo-reload pulses and drives the pause/looser overlay flags.

---
 rtl/ctl_round.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/ctl_round.sv
// ctl_round: game-flow controller for Duck Hunt.
// Sequences ducks within a round, counts hits, decides pass/fail and
// drives the BCD round number plus the pause/looser overlay flags.
// Optional feature macro: PRACTICE_MODE_EN (a failed round replays the
// same round instead of ending the game).

module ctl_round #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int HITS_TO_PASS    = 6,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int INTRO_FRAMES    = 120,
  parameter int GAP_FRAMES      = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       new_frame,
  input  logic                       start,
  input  logic                       hit,
  input  logic                       miss,
  input  logic                       shot_fired,
  input  logic                       duck_gone,
  output logic                       duck_release,
  output logic                       reload,
  output logic                       pause,
  output logic                       looser,
  output logic [3:0]                 round_hex1,
  output logic [3:0]                 round_hex0,
  output logic [3:0]                 hits_in_round,
  output logic [DUCKS_PER_ROUND-1:0] led_hits
);

  localparam int CNT_MAX = (INTRO_FRAMES > GAP_FRAMES) ? INTRO_FRAMES : GAP_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    INTRO,
    FLY,
    DUCK_END,
    ROUND_END,
    GAME_OVER
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]           frame_cnt, frame_cnt_nx;
  logic [3:0]                 duck_idx, duck_idx_nx;
  logic [2:0]                 shots, shots_nx;
  logic [3:0]                 hex1_nx, hex0_nx, hits_nx;
  logic [DUCKS_PER_ROUND-1:0] led_nx;
  logic                       release_nx, reload_nx, pause_nx, looser_nx;

  logic [2:0] shots_fly;
  logic       escape;
  logic       intro_done;
  logic       gap_done;
  logic       last_duck;
  logic       round_pass;

  // Shot count including a shot fired this cycle, so a miss on the final
  // shot is recognised in the same cycle as that shot.
  assign shots_fly  = (shot_fired && (shots != 3'(SHOTS_PER_DUCK))) ? shots + 3'd1 : shots;
  assign escape     = duck_gone || (miss && (shots_fly == 3'(SHOTS_PER_DUCK)));
  assign intro_done = new_frame && (frame_cnt == CNT_W'(INTRO_FRAMES - 1));
  assign gap_done   = new_frame && (frame_cnt == CNT_W'(GAP_FRAMES - 1));
  assign last_duck  = (duck_idx == 4'(DUCKS_PER_ROUND - 1));
  assign round_pass = (hits_in_round >= 4'(HITS_TO_PASS));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start restarts the game from any state.
  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = INTRO;
    end else begin
      case (state)
        IDLE:      state_nx = IDLE;
        INTRO:     if (intro_done) state_nx = FLY;
        FLY:       if (hit || escape) state_nx = DUCK_END;
        DUCK_END:  if (gap_done) state_nx = last_duck ? ROUND_END : FLY;
`ifdef PRACTICE_MODE_EN
        ROUND_END: state_nx = INTRO;
`else
        ROUND_END: state_nx = round_pass ? INTRO : GAME_OVER;
`endif
        GAME_OVER: state_nx = GAME_OVER;
        default:   state_nx = IDLE;
      endcase
    end
  end

  // Next values for counters and registered outputs.
  always_comb begin
    frame_cnt_nx = frame_cnt;
    duck_idx_nx  = duck_idx;
    shots_nx     = shots;
    hex1_nx      = round_hex1;
    hex0_nx      = round_hex0;
    hits_nx      = hits_in_round;
    led_nx       = led_hits;
    release_nx   = 1'b0;
    reload_nx    = 1'b0;
    if (start) begin
      frame_cnt_nx = '0;
      duck_idx_nx  = 4'd0;
      shots_nx     = 3'd0;
      hex1_nx      = 4'd0;
      hex0_nx      = 4'd1;
      hits_nx      = 4'd0;
      led_nx       = '0;
      reload_nx    = 1'b1;
    end else begin
      case (state)
        INTRO: begin
          if (intro_done) begin
            frame_cnt_nx = '0;
            shots_nx     = 3'd0;
            release_nx   = 1'b1;
          end else if (new_frame) begin
            frame_cnt_nx = frame_cnt + CNT_W'(1);
          end
        end
        FLY: begin
          shots_nx = shots_fly;
          if (hit) begin
            hits_nx = hits_in_round + 4'd1;
            for (int i = 0; i < DUCKS_PER_ROUND; i++) begin
              if (duck_idx == 4'(i)) led_nx[i] = 1'b1;
            end
          end
        end
        DUCK_END: begin
          if (gap_done) begin
            frame_cnt_nx = '0;
            if (!last_duck) begin
              duck_idx_nx = duck_idx + 4'd1;
              shots_nx    = 3'd0;
              release_nx  = 1'b1;
              reload_nx   = 1'b1;
            end
          end else if (new_frame) begin
            frame_cnt_nx = frame_cnt + CNT_W'(1);
          end
        end
        ROUND_END: begin
          if (round_pass) begin
            if (round_hex0 == 4'd9) begin
              if (round_hex1 != 4'd9) begin
                hex0_nx = 4'd0;
                hex1_nx = round_hex1 + 4'd1;
              end
            end else begin
              hex0_nx = round_hex0 + 4'd1;
            end
            hits_nx     = 4'd0;
            led_nx      = '0;
            duck_idx_nx = 4'd0;
            reload_nx   = 1'b1;
          end else begin
`ifdef PRACTICE_MODE_EN
            hits_nx     = 4'd0;
            led_nx      = '0;
            duck_idx_nx = 4'd0;
            reload_nx   = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
    pause_nx  = !((state_nx == FLY) || (state_nx == DUCK_END) || (state_nx == ROUND_END));
    looser_nx = (state_nx == GAME_OVER);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt     <= '0;
      duck_idx      <= 4'd0;
      shots         <= 3'd0;
      round_hex1    <= 4'd0;
      round_hex0    <= 4'd1;
      hits_in_round <= 4'd0;
      led_hits      <= '0;
      duck_release  <= 1'b0;
      reload        <= 1'b0;
      pause         <= 1'b1;
      looser        <= 1'b0;
    end else begin
      frame_cnt     <= frame_cnt_nx;
      duck_idx      <= duck_idx_nx;
      shots         <= shots_nx;
      round_hex1    <= hex1_nx;
      round_hex0    <= hex0_nx;
      hits_in_round <= hits_nx;
      led_hits      <= led_nx;
      duck_release  <= release_nx;
      reload        <= reload_nx;
      pause         <= pause_nx;
      looser        <= looser_nx;
    end
  end

endmodule
